// File: rtl/conv_mac_pkg.sv
// Shared definitions for the convolution MAC accumulation cell.
// Contents:
//   cal_fmt_e - operand format codes carried on calfmt
//   clog2     - ceiling log2, used to size the lane adder output
package conv_mac_pkg;

    typedef enum logic [1:0] {
        CAL_FMT_INT8  = 2'b00,
        CAL_FMT_INT16 = 2'b01,
        CAL_FMT_FP16  = 2'b10,
        CAL_FMT_RSVD  = 2'b11
    } cal_fmt_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_mac_acc_cell_if.sv
// Stream bundle for conv_mac_acc_cell: input beat channel (calfmt, ftm/wgt
// lanes, last, valid/ready) and output result channel (data, sat,
// valid/ready).
//   master - producer of beats / consumer of results (the surrounding system)
//   slave  - the MAC accumulation cell
interface conv_mac_acc_cell_if #(
    parameter int unsigned ATOMIC_C  = 4,
    parameter int unsigned ACC_WIDTH = 40
);
    logic [1:0]              calfmt;
    logic [ATOMIC_C*16-1:0]  mac_in_ftm;
    logic [ATOMIC_C*16-1:0]  mac_in_wgt;
    logic                    mac_in_last;
    logic                    mac_in_valid;
    logic                    mac_in_ready;
    logic [ACC_WIDTH-1:0]    mac_out_data;
    logic                    mac_out_sat;
    logic                    mac_out_valid;
    logic                    mac_out_ready;

    modport master (
        output calfmt, mac_in_ftm, mac_in_wgt, mac_in_last, mac_in_valid,
        input  mac_in_ready,
        input  mac_out_data, mac_out_sat, mac_out_valid,
        output mac_out_ready
    );

    modport slave (
        input  calfmt, mac_in_ftm, mac_in_wgt, mac_in_last, mac_in_valid,
        output mac_in_ready,
        output mac_out_data, mac_out_sat, mac_out_valid,
        input  mac_out_ready
    );
endinterface

// File: rtl/conv_mac_add_tree.sv
// Registered signed lane adder: sums LANES signed IN_W-bit values into one
// signed IN_W+clog2(LANES)-bit result, registered when en is high.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears the sum)
//   en        - register enable
//   in_data   - LANES packed signed inputs, lane 0 in the low bits
//   sum       - registered signed sum
module conv_mac_add_tree
    import conv_mac_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned IN_W  = 32,
    localparam int unsigned OUT_W = IN_W + clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [LANES*IN_W-1:0]   in_data,
    output logic signed [OUT_W-1:0] sum
);

    logic signed [OUT_W-1:0] sum_c;

    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum_c = sum_c + OUT_W'($signed(in_data[i*IN_W +: IN_W]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum_c;
        end
    end

endmodule

// File: rtl/conv_mac_acc_cell.sv
// Convolution MAC accumulation cell. Formats ATOMIC_C feature/weight lanes
// for external signed 16x16 multipliers, sums the returned products per beat
// and accumulates beats into a saturating group sum emitted on mac_in_last.
// Ports:
//   aclk, areset - clock, asynchronous active-high reset
//   aclken       - global clock enable
//   mac          - beat input / result output streams (slave side)
//   err_fmt      - one-cycle pulse after accepting an FP16/reserved beat
//   mul_op_a/b   - registered operands to the external multipliers
//   mul_ce       - multiplier enable (equals the pipeline enable)
//   mul_res      - products, MUL_LATENCY enabled cycles after the operands
module conv_mac_acc_cell
    import conv_mac_pkg::*;
#(
    parameter int unsigned ATOMIC_C    = 4,
    parameter int unsigned ACC_WIDTH   = 40,
    parameter int unsigned MUL_LATENCY = 1,
    parameter int unsigned SIM_DELAY   = 1
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   aclken,
    conv_mac_acc_cell_if.slave     mac,
    output logic                   err_fmt,
    output logic [ATOMIC_C*16-1:0] mul_op_a,
    output logic [ATOMIC_C*16-1:0] mul_op_b,
    output logic                   mul_ce,
    input  logic [ATOMIC_C*32-1:0] mul_res
);

    localparam int unsigned SW = 32 + clog2(ATOMIC_C);
    // Extended width covers both the lane sum and the accumulator plus one
    // guard bit, so the raw sum never wraps before clipping is decided.
    localparam int unsigned EW = ((SW > ACC_WIDTH) ? SW : ACC_WIDTH) + 1;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX_N = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN_N = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [EW-1:0] ACC_MAX_W = {{(EW-ACC_WIDTH){1'b0}}, ACC_MAX_N};
    localparam logic signed [EW-1:0] ACC_MIN_W = {{(EW-ACC_WIDTH){1'b1}}, ACC_MIN_N};

    if ((ATOMIC_C == 0) || (ATOMIC_C > 32) || ((ATOMIC_C & (ATOMIC_C - 1)) != 0) ||
        (ACC_WIDTH < 34) || (ACC_WIDTH > 48) ||
        (MUL_LATENCY < 1) || (MUL_LATENCY > 4) || (SIM_DELAY > 1000)) begin : g_bad_param
        $error("conv_mac_acc_cell: parameter out of range");
    end

    logic                   pipe_en;
    logic [ATOMIC_C*16-1:0] op_a_d;
    logic [ATOMIC_C*16-1:0] op_b_d;
    logic [MUL_LATENCY:0]   tag_v;
    logic [MUL_LATENCY:0]   tag_last;
    logic signed [SW-1:0]   lane_sum;
    logic                   sum_v;
    logic                   sum_last;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                   sticky;
    logic signed [EW-1:0]   acc_ext;
    logic signed [EW-1:0]   sum_ext;
    logic signed [EW-1:0]   wide;
    logic                   clip;
    logic [ACC_WIDTH-1:0]   next_acc;
    logic [ACC_WIDTH-1:0]   out_data_q;
    logic                   out_sat_q;
    logic                   out_valid_q;
    logic                   bad_fmt;

    assign pipe_en           = aclken & (~out_valid_q | mac.mac_out_ready);
    assign mac.mac_in_ready  = pipe_en;
    assign mul_ce            = pipe_en;
    assign mac.mac_out_data  = out_data_q;
    assign mac.mac_out_sat   = out_sat_q;
    assign mac.mac_out_valid = out_valid_q;

    assign bad_fmt = (mac.calfmt == CAL_FMT_FP16) || (mac.calfmt == CAL_FMT_RSVD);

    // Operand formatting; unsupported formats feed zeros so the beat still
    // flows through and its last tag is honoured.
    always_comb begin
        op_a_d = '0;
        op_b_d = '0;
        for (int unsigned i = 0; i < ATOMIC_C; i++) begin
            case (mac.calfmt)
                CAL_FMT_INT16: begin
                    op_a_d[i*16 +: 16] = mac.mac_in_ftm[i*16 +: 16];
                    op_b_d[i*16 +: 16] = mac.mac_in_wgt[i*16 +: 16];
                end
                CAL_FMT_INT8: begin
                    op_a_d[i*16 +: 16] = {{8{mac.mac_in_ftm[i*16+7]}}, mac.mac_in_ftm[i*16 +: 8]};
                    op_b_d[i*16 +: 16] = {{8{mac.mac_in_wgt[i*16+7]}}, mac.mac_in_wgt[i*16 +: 8]};
                end
                default: ;
            endcase
        end
    end

    // Data path is qualified by the tags only, so it carries no reset.
    always_ff @(posedge aclk) begin
        if (pipe_en) begin
            mul_op_a <= op_a_d;
            mul_op_b <= op_b_d;
        end
    end

    // tag[0] sits with the operand register, tag[MUL_LATENCY] with mul_res.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tag_v    <= '0;
            tag_last <= '0;
        end else if (pipe_en) begin
            tag_v    <= {tag_v[MUL_LATENCY-1:0], mac.mac_in_valid};
            tag_last <= {tag_last[MUL_LATENCY-1:0], mac.mac_in_last};
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_fmt <= 1'b0;
        end else begin
            err_fmt <= pipe_en & mac.mac_in_valid & bad_fmt;
        end
    end

    conv_mac_add_tree #(
        .LANES (ATOMIC_C),
        .IN_W  (32)
    ) u_add_tree (
        .clk     (aclk),
        .rst     (areset),
        .en      (pipe_en),
        .in_data (mul_res),
        .sum     (lane_sum)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sum_v    <= 1'b0;
            sum_last <= 1'b0;
        end else if (pipe_en) begin
            sum_v    <= tag_v[MUL_LATENCY];
            sum_last <= tag_last[MUL_LATENCY];
        end
    end

    always_comb begin
        acc_ext = {{(EW-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
        sum_ext = {{(EW-SW){lane_sum[SW-1]}}, lane_sum};
        wide    = acc_ext + sum_ext;
        clip    = 1'b0;
        if (wide > ACC_MAX_W) begin
            next_acc = ACC_MAX_N;
            clip     = 1'b1;
        end else if (wide < ACC_MIN_W) begin
            next_acc = ACC_MIN_N;
            clip     = 1'b1;
        end else begin
            next_acc = wide[ACC_WIDTH-1:0];
        end
    end

    // A last sum loads the output and restarts the accumulator in the same
    // edge; that load takes priority over the ready-driven valid clear.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            acc         <= '0;
            sticky      <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (pipe_en) begin
            if (sum_v && sum_last) begin
                out_data_q  <= next_acc;
                out_sat_q   <= sticky | clip;
                out_valid_q <= 1'b1;
                acc         <= '0;
                sticky      <= 1'b0;
            end else begin
                if (sum_v) begin
                    acc    <= $signed(next_acc);
                    sticky <= sticky | clip;
                end
                if (mac.mac_out_ready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_acc_cell.sv
// Directed bench for conv_mac_acc_cell: a default-width instance (ACC_WIDTH
// 40) and a 34-bit instance for saturation, each with a one-cycle
// behavioural multiplier array.
module tb_conv_mac_acc_cell;
    import conv_mac_pkg::*;

    logic        aclk = 1'b0;
    logic        areset;
    logic        aclken;
    logic        in_valid;
    logic        in_last;
    logic [63:0] in_ftm;
    logic [63:0] in_wgt;
    logic [1:0]  calfmt;
    logic        out_ready;
    logic        sel34;

    int n_assert = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int err_cnt  = 0;

    always #5 aclk = ~aclk;

    conv_mac_acc_cell_if #(.ATOMIC_C(4), .ACC_WIDTH(40)) m_if ();
    conv_mac_acc_cell_if #(.ATOMIC_C(4), .ACC_WIDTH(34)) s_if ();

    assign m_if.calfmt        = calfmt;
    assign m_if.mac_in_ftm    = in_ftm;
    assign m_if.mac_in_wgt    = in_wgt;
    assign m_if.mac_in_last   = in_last;
    assign m_if.mac_in_valid  = in_valid & ~sel34;
    assign m_if.mac_out_ready = out_ready;
    assign s_if.calfmt        = calfmt;
    assign s_if.mac_in_ftm    = in_ftm;
    assign s_if.mac_in_wgt    = in_wgt;
    assign s_if.mac_in_last   = in_last;
    assign s_if.mac_in_valid  = in_valid & sel34;
    assign s_if.mac_out_ready = out_ready;

    logic [63:0]  ma_m, mb_m, ma_s, mb_s;
    logic [127:0] mr_m, mr_s;
    logic         ce_m, ce_s, err_m, err_s;

    conv_mac_acc_cell #(.ATOMIC_C(4), .ACC_WIDTH(40), .MUL_LATENCY(1), .SIM_DELAY(1)) dut (
        .aclk(aclk), .areset(areset), .aclken(aclken), .mac(m_if.slave),
        .err_fmt(err_m), .mul_op_a(ma_m), .mul_op_b(mb_m), .mul_ce(ce_m), .mul_res(mr_m)
    );

    conv_mac_acc_cell #(.ATOMIC_C(4), .ACC_WIDTH(34), .MUL_LATENCY(1), .SIM_DELAY(1)) dut34 (
        .aclk(aclk), .areset(areset), .aclken(aclken), .mac(s_if.slave),
        .err_fmt(err_s), .mul_op_a(ma_s), .mul_op_b(mb_s), .mul_ce(ce_s), .mul_res(mr_s)
    );

    // External multipliers, one enabled cycle of latency.
    always @(posedge aclk) begin
        if (ce_m) for (int i = 0; i < 4; i++)
            mr_m[i*32 +: 32] <= $signed(ma_m[i*16 +: 16]) * $signed(mb_m[i*16 +: 16]);
        if (ce_s) for (int i = 0; i < 4; i++)
            mr_s[i*32 +: 32] <= $signed(ma_s[i*16 +: 16]) * $signed(mb_s[i*16 +: 16]);
    end

    logic               o_valid, o_sat, o_err, o_ready, o_ce;
    logic signed [63:0] o_data;
    assign o_valid = sel34 ? s_if.mac_out_valid : m_if.mac_out_valid;
    assign o_sat   = sel34 ? s_if.mac_out_sat   : m_if.mac_out_sat;
    assign o_err   = sel34 ? err_s : err_m;
    assign o_ready = sel34 ? s_if.mac_in_ready  : m_if.mac_in_ready;
    assign o_ce    = sel34 ? ce_s : ce_m;
    assign o_data  = sel34 ? {{30{s_if.mac_out_data[33]}}, s_if.mac_out_data}
                           : {{24{m_if.mac_out_data[39]}}, m_if.mac_out_data};

    always @(posedge aclk) begin
        if (o_valid && out_ready) hs_cnt++;
        if (o_err) err_cnt++;
    end

    function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one beat and hold it until accepted (bounded), return #1 after
    // the accepting edge.
    task automatic send(input logic [1:0] fmt, input logic [63:0] f, input logic [63:0] w,
                        input logic last);
        calfmt = fmt; in_ftm = f; in_wgt = w; in_last = last; in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge aclk);
            if (o_ready) break;
        end
        chk("send_ready", o_ready, 1);
        @(posedge aclk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!o_valid && lat < 30) begin
            @(posedge aclk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int h0;
        int e0;
        int n;
        logic signed [63:0] got [2];

        areset = 1'b1; aclken = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        in_ftm = '0; in_wgt = '0; calfmt = 2'b01; out_ready = 1'b1; sel34 = 1'b0;
        got[0] = '0; got[1] = '0;

        // Reset state
        repeat (2) @(posedge aclk); #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_sat", o_sat, 0);
        chk("rst_err", o_err, 0);
        chk("rst_in_ready", o_ready, 1);
        areset = 1'b0;
        @(posedge aclk); #1;

        // INT16 single-beat group: 1*-1 + 2*2 + 3*-3 + 4*4 = 10
        send(2'b01, pk(1, 2, 3, 4), pk(-1, 2, -3, 4), 1'b1);
        wait_out(lat);
        chk("t1_latency", lat, 3);
        chk("t1_valid", o_valid, 1);
        chk("t1_data", o_data, 10);
        chk("t1_sat", o_sat, 0);
        @(posedge aclk); #1;
        chk("t1_valid_clear", o_valid, 0);

        // INT8 group: lanes 0x7F * 0xFF(-1) = -127, x4 lanes x3 beats = -1524
        h0 = hs_cnt;
        send(2'b00, {4{16'hAB7F}}, {4{16'h00FF}}, 1'b0);
        send(2'b00, {4{16'hAB7F}}, {4{16'h00FF}}, 1'b0);
        send(2'b00, {4{16'hAB7F}}, {4{16'h00FF}}, 1'b1);
        wait_out(lat);
        chk("t2_data", o_data, -1524);
        chk("t2_sat", o_sat, 0);
        repeat (4) @(posedge aclk); #1;
        chk("t2_out_count", hs_cnt - h0, 1);

        // Backpressure: two queued groups, 24 then 700
        out_ready = 1'b0;
        send(2'b01, pk(2, 2, 2, 2), pk(3, 3, 3, 3), 1'b1);
        send(2'b01, pk(100, 0, 0, 0), pk(7, 0, 0, 0), 1'b1);
        wait_out(lat);
        chk("t3_valid", o_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk("t3_in_ready", o_ready, 0);
            chk("t3_mul_ce", o_ce, 0);
            chk("t3_hold_data", o_data, 24);
        end
        out_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 20 && n < 2; k++) begin
            if (o_valid) begin
                got[n] = o_data;
                n++;
            end
            if (n < 2) begin
                @(posedge aclk); #1;
            end
        end
        chk("t3_group_a", got[0], 24);
        chk("t3_group_b", got[1], 700);

        // Format change mid-group: INT16 256*2 = 512, then INT8 3*2*4 = 24
        send(2'b01, pk(256, 0, 0, 0), pk(2, 0, 0, 0), 1'b0);
        send(2'b00, pk(259, 259, 259, 259), pk(2, 2, 2, 2), 1'b1);
        wait_out(lat);
        chk("t4_mixed_fmt", o_data, 536);

        // Unsupported format: zero operands, one err pulse, group still closes
        e0 = err_cnt;
        send(2'b10, pk(4660, 4660, 4660, 4660), pk(17, 17, 17, 17), 1'b1);
        chk("t5_err_pulse", o_err, 1);
        wait_out(lat);
        chk("t5_valid", o_valid, 1);
        chk("t5_data", o_data, 0);
        repeat (3) @(posedge aclk); #1;
        chk("t5_err_count", err_cnt - e0, 1);

        // Reset mid-group: partial sums discarded, new group gives 20 only
        send(2'b01, pk(1000, 1000, 1000, 1000), pk(1000, 1000, 1000, 1000), 1'b0);
        send(2'b01, pk(1000, 1000, 1000, 1000), pk(1000, 1000, 1000, 1000), 1'b0);
        #2 areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        h0 = hs_cnt;
        send(2'b01, pk(1, 1, 1, 1), pk(5, 5, 5, 5), 1'b1);
        wait_out(lat);
        chk("t6_data", o_data, 20);
        repeat (4) @(posedge aclk); #1;
        chk("t6_out_count", hs_cnt - h0, 1);

        // Saturation on the 34-bit instance: 2 beats of 4 * 2^30 = 2^33 clips
        sel34 = 1'b1;
        @(posedge aclk); #1;
        send(2'b01, {4{16'h8000}}, {4{16'h8000}}, 1'b0);
        send(2'b01, {4{16'h8000}}, {4{16'h8000}}, 1'b1);
        wait_out(lat);
        chk("t7_sat_data", o_data, 64'sd8589934591);
        chk("t7_sat_flag", o_sat, 1);
        send(2'b01, pk(1, 1, 1, 1), pk(5, 5, 5, 5), 1'b1);
        wait_out(lat);
        chk("t7_next_data", o_data, 20);
        chk("t7_next_sat", o_sat, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_mac_acc_cell.md
CONV_MAC_ACC_CELL -- requirements
Module: conv_mac_acc_cell

Interface
REQ-001 The module SHALL have parameter ATOMIC_C, default 4, which sets the channel lanes per beat (1|2|4|8|16|32).
REQ-002 The module SHALL have parameter ACC_WIDTH, default 40, which sets the signed accumulator and output width (range 34..48).
REQ-003 The module SHALL have parameter MUL_LATENCY, default 1, which sets the external multiplier latency in ce-enabled cycles (1..4).
REQ-004 The module SHALL have parameter SIM_DELAY, default 1, which sets the register assignment delay used for simulation.
REQ-005 The ports SHALL be as follows:
- aclk  in  1  clock.
- areset  in  1  asynchronous reset, active-high (one clock; reset is asynchronous and active-high).
- aclken  in  1  global clock enable.
- calfmt  in  2  operand format: 00 INT8, 01 INT16, 10 FP16 (unsupported), 11 reserved.
- mac_in_ftm  in  ATOMIC_C*16  feature-map lanes.
- mac_in_wgt  in  ATOMIC_C*16  weight lanes.
- mac_in_last  in  1  beat closes the current accumulation group.
- mac_in_valid / mac_in_ready  in/out  1  input handshake.
- mac_out_data  out  ACC_WIDTH  signed group sum.
- mac_out_sat  out  1  group saturated.
- mac_out_valid / mac_out_ready  out/in  1  output handshake.
- err_fmt  out  1  one-cycle pulse for a beat accepted with calfmt 10 or 11.
- mul_op_a, mul_op_b  out  ATOMIC_C*16  operands to the external signed 16x16 multipliers.
- mul_ce  out  1  multiplier enable.
- mul_res  in  ATOMIC_C*32  products, valid MUL_LATENCY enabled cycles after the operands.

Function
REQ-006 The global pipeline enable SHALL be pipe_en = aclken & (~mac_out_valid | mac_out_ready), with mac_in_ready = pipe_en and mul_ce = pipe_en.
REQ-007 A beat SHALL be accepted on a rising edge where mac_in_valid & mac_in_ready are both high.
REQ-008 When pipe_en is low, every pipeline register, the valid tag and the accumulator SHALL hold, so that no beat is lost or duplicated.
REQ-009 In INT16 mode, lanes SHALL pass unchanged to mul_op_a (ftm) and mul_op_b (wgt).
REQ-010 In INT8 mode, each lane's low byte SHALL be sign-extended to 16 bits and the high byte ignored.
REQ-011 In calfmt 10 or 11, operands SHALL be forced to 0, err_fmt SHALL pulse in the cycle after acceptance, and mac_in_last SHALL still be honoured.
REQ-012 The valid and last tags SHALL travel in a shift pipeline of MUL_LATENCY stages that is aligned to mul_res.
REQ-013 The ATOMIC_C products SHALL be summed in one registered stage at width 32+log2(ATOMIC_C), sign-extended to ACC_WIDTH.
REQ-014 On each tagged sum, next = acc + sum SHALL be computed with saturation to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], and a sticky sat flag SHALL be set whenever clipping occurs.
REQ-015 On a non-last sum, acc <= next.
REQ-016 On a last sum, mac_out_data <= next, mac_out_sat <= sticky|clip, mac_out_valid <= 1, acc <= 0 and sticky <= 0, so that back-to-back groups carry no bubble.
REQ-017 Latency from acceptance of a last beat to mac_out_valid high SHALL be MUL_LATENCY+2 enabled cycles.
REQ-018 mac_out_valid SHALL clear on the edge where mac_out_ready is high, unless a new last sum loads on that same edge, in which case valid stays high with the new data.
REQ-019 mac_out_data and mac_out_sat SHALL remain stable while mac_out_valid=1 and mac_out_ready=0.
REQ-020 calfmt SHALL be sampled per beat at acceptance; changing it mid-group is legal, and each beat uses its own format.
REQ-021 A group of one beat (mac_in_last on its first beat) SHALL be legal.

Reset
REQ-022 While areset=1, all of the following SHALL be 0 asynchronously: the pipeline valid/last tags, the sum register, acc, sticky, mac_out_data, mac_out_sat, mac_out_valid and err_fmt.
REQ-023 An assertion of areset in the middle of a group SHALL discard every in-flight beat and partial sum, and the first beat after release SHALL start a new group.
REQ-024 The multiplier data path need not be reset, because only the tags qualify it.

Structure
REQ-025 Package conv_mac_pkg SHALL hold the CAL_FMT_INT8, CAL_FMT_INT16 and CAL_FMT_FP16 constants and a clog2 helper function.
REQ-026 The registered lane adder SHALL be a sub-module conv_mac_add_tree, parameterised by lane count and input width.
REQ-027 The multipliers SHALL remain external to this module.

Verification (ATOMIC_C=4, MUL_LATENCY=1 unless stated)
REQ-028 Scenario INT16 single beat: ftm {1,2,3,4}, wgt {-1,2,-3,4}, last=1 -> mac_out_data=10 with mac_out_valid high 3 cycles after acceptance, sat=0.
REQ-029 Scenario INT8 group: 3 beats, every ftm lane 0xAB7F, every wgt lane 0x00FF, last on beat 3 -> a single output of -1524; no output after beats 1-2.
REQ-030 Scenario backpressure: mac_out_ready held low 5 cycles with a result pending -> mac_in_ready=0, mul_ce=0, mac_out_data held; after release, the queued groups emerge in order with correct sums.
REQ-031 Scenario saturation (ACC_WIDTH=34): all INT16 lanes ftm=wgt=-32768, 2 beats -> mac_out_data=8589934591, mac_out_sat=1; the next group reports sat=0.
REQ-032 Scenario unsupported format: calfmt=10 on a single last beat -> err_fmt pulses once, mac_out_data=0.
REQ-033 Scenario reset mid-group: areset pulsed after 2 non-last beats, then a single INT16 beat ftm {1,1,1,1}, wgt {5,5,5,5} -> output 20 only.
